// File: rtl/alu_pkg.sv
// Shared definitions for the serial-controlled ALU: default widths,
// FSM state encoding for the UART front end and the ALU opcode map.
package alu_pkg;

  localparam int NB_DATA_DEFAULT   = 8;
  localparam int NB_OPCODE_DEFAULT = 6;

  // Front-end FSM state encoding
  localparam int NB_STATE = 3;

  typedef enum logic [NB_STATE-1:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_LATCH   = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } uart_intf_state_t;

  // ALU opcodes (MIPS-style funct codes)
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_AND = 6'h24;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OPCODE_DEFAULT-1:0] OP_SRL = 6'h02;

endpackage

// File: rtl/frame_timeout_counter.sv
// Idle-cycle counter for a partially received frame. Counts enabled cycles
// and flags the cycle in which the count sits at TIMEOUT_CYCLES-1 while
// still enabled; clear has priority and restarts the count from zero.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int NB_CNT = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] LAST_COUNT = NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [NB_CNT-1:0] count_q;
  logic [NB_CNT-1:0] count_d;

  // Terminal only while still idling; a clear in the same cycle wins
  assign o_terminal = i_enable && !i_clear && (count_q == LAST_COUNT);

  // Next count: clear, hold, or advance (wraps at terminal; the FSM leaves anyway)
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = (count_q == LAST_COUNT) ? '0 : count_q + NB_CNT'(1);
    end
  end

  // Count register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_uart_intf.sv
// UART byte-stream front end for the ALU: collects A, B and opcode bytes,
// presents them to the combinational ALU, captures the result and hands it
// to the transmitter with a one-cycle start pulse. Partial frames that go
// idle for too long are abandoned with a timeout pulse.
module alu_uart_intf
  import alu_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEFAULT,
  parameter int NB_OPCODE      = NB_OPCODE_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic [NB_DATA-1:0]   o_dato_a,
  output logic [NB_DATA-1:0]   o_dato_b,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_timeout
);

  uart_intf_state_t state_q, state_d;
  logic [NB_DATA-1:0]   dato_a_q, dato_a_d;
  logic [NB_DATA-1:0]   dato_b_q, dato_b_d;
  logic [NB_OPCODE-1:0] opcode_q, opcode_d;
  logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;

  logic in_frame;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_terminal;

  // Only the middle of a frame is time-limited; any accepted byte restarts it
  assign in_frame   = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
  assign cnt_clear  = !in_frame || i_rx_done;
  assign cnt_enable = in_frame && !i_rx_done;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (cnt_clear),
    .i_enable  (cnt_enable),
    .o_terminal(cnt_terminal)
  );

  // Next-state and next-output logic; outputs are derived from the next state
  // so that they are registered alongside it
  always_comb begin
    state_d   = state_q;
    dato_a_d  = dato_a_q;
    dato_b_d  = dato_b_q;
    opcode_d  = opcode_q;
    tx_data_d = tx_data_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          dato_a_d = i_rx_data;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          dato_b_d = i_rx_data;
          state_d  = ST_WAIT_OP;
        end else if (cnt_terminal) begin
          timeout_d = 1'b1;
          state_d   = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          opcode_d = i_rx_data[NB_OPCODE-1:0];
          state_d  = ST_LATCH;
        end else if (cnt_terminal) begin
          timeout_d = 1'b1;
          state_d   = ST_WAIT_A;
        end
      end
      ST_LATCH: begin
        tx_data_d = i_alu_result;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_d = ST_WAIT_A;
        end
      end
      default: begin
        state_d = ST_WAIT_A;
      end
    endcase

    tx_start_d = (state_d == ST_SEND);
    busy_d     = (state_d == ST_LATCH) || (state_d == ST_SEND) ||
                 (state_d == ST_WAIT_TX);
  end

  // FSM state and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_WAIT_A;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      opcode_q   <= opcode_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_dato_a   = dato_a_q;
  assign o_dato_b   = dato_b_q;
  assign o_opcode   = opcode_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_alu_uart_intf.sv
// Self-checking bench for alu_uart_intf: directed frames, timeout and reset
// scenarios plus randomized frames, checked against a frame-level model.
module tb_alu_uart_intf;
  import alu_pkg::*;

  localparam int NB_DATA   = 8;
  localparam int NB_OPCODE = 6;
  localparam int T         = 16;

  logic                 clk = 1'b0;
  logic                 i_reset;
  logic [NB_DATA-1:0]   i_rx_data;
  logic                 i_rx_done;
  logic                 i_tx_done;
  logic [NB_DATA-1:0]   i_alu_result;
  logic [NB_DATA-1:0]   o_dato_a;
  logic [NB_DATA-1:0]   o_dato_b;
  logic [NB_OPCODE-1:0] o_opcode;
  logic [NB_DATA-1:0]   o_tx_data;
  logic                 o_tx_start;
  logic                 o_busy;
  logic                 o_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_tmo    = 0;

  // Reference model state: what the operand registers must hold
  logic [NB_DATA-1:0]   exp_a, exp_b;
  logic [NB_OPCODE-1:0] exp_op;

  always #5 clk = ~clk;

  alu_uart_intf #(
    .NB_DATA       (NB_DATA),
    .NB_OPCODE     (NB_OPCODE),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .i_tx_done   (i_tx_done),
    .i_alu_result(i_alu_result),
    .o_dato_a    (o_dato_a),
    .o_dato_b    (o_dato_b),
    .o_opcode    (o_opcode),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  // Behavioural ALU
  function automatic logic [NB_DATA-1:0] alu_ref(input logic [NB_DATA-1:0] a,
                                                 input logic [NB_DATA-1:0] b,
                                                 input logic [NB_OPCODE-1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return NB_DATA'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      default: return '0;
    endcase
  endfunction

  assign i_alu_result = alu_ref(o_dato_a, o_dato_b, o_opcode);

  // Pulse counters observed on the clock edge
  always @(posedge clk) begin
    if (o_tx_start) n_start++;
    if (o_timeout)  n_tmo++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a negedge
  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"},     32'(o_dato_a),   0);
    chk({tag, "_b"},     32'(o_dato_b),   0);
    chk({tag, "_op"},    32'(o_opcode),   0);
    chk({tag, "_txd"},   32'(o_tx_data),  0);
    chk({tag, "_start"}, 32'(o_tx_start), 0);
    chk({tag, "_busy"},  32'(o_busy),     0);
    chk({tag, "_tmo"},   32'(o_timeout),  0);
    exp_a = '0; exp_b = '0; exp_op = '0;
  endtask

  task automatic pulse_reset(input int n);
    i_reset = 1'b1;
    idle(n);
    i_reset = 1'b0;
  endtask

  // Full frame with exact latency checks; drop_at<0 means no dropped byte
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input int gap1, input int gap2, input bit drop_latch,
                          input int drop_at, input int txdelay);
    int s0, t0;
    logic [NB_DATA-1:0] exp_res;
    s0 = n_start; t0 = n_tmo;
    send_byte(a);    exp_a = a;
    chk("frm_a", 32'(o_dato_a), 32'(exp_a));
    idle(gap1);
    send_byte(b);    exp_b = b;
    chk("frm_b", 32'(o_dato_b), 32'(exp_b));
    idle(gap2);
    send_byte(opb);  exp_op = opb[NB_OPCODE-1:0];
    exp_res = alu_ref(exp_a, exp_b, exp_op);
    chk("frm_op", 32'(o_opcode), 32'(exp_op));
    // LATCH cycle
    chk("lat_start", 32'(o_tx_start), 0);
    chk("lat_busy",  32'(o_busy),     1);
    if (drop_latch) begin
      send_byte(8'h5A);
    end else begin
      @(negedge clk);
    end
    // SEND cycle
    chk("snd_start", 32'(o_tx_start), 1);
    chk("snd_txd",   32'(o_tx_data),  32'(exp_res));
    chk("snd_busy",  32'(o_busy),     1);
    @(negedge clk);
    chk("wtx_start", 32'(o_tx_start), 0);
    for (int i = 0; i < txdelay; i++) begin
      if (i == drop_at) send_byte(8'h77);
      else              @(negedge clk);
    end
    chk("wtx_busy", 32'(o_busy),    1);
    chk("wtx_txd",  32'(o_tx_data), 32'(exp_res));
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    chk("done_busy",   32'(o_busy),   0);
    chk("done_a_kept", 32'(o_dato_a), 32'(exp_a));
    chk("done_b_kept", 32'(o_dato_b), 32'(exp_b));
    chk("frm_nstart",  32'(n_start - s0), 1);
    chk("frm_ntmo",    32'(n_tmo - t0),   0);
    $display("frame a=0x%02h b=0x%02h op=0x%02h gaps=%0d/%0d result=0x%02h tx_data=0x%02h",
             a, b, exp_op, gap1, gap2, exp_res, o_tx_data);
  endtask

  // Abandoned frame: bytes_in = 1 (stall in WAIT_B) or 2 (stall in WAIT_OP)
  task automatic do_timeout(input int bytes_in, input logic [7:0] a, input logic [7:0] b);
    int t0;
    t0 = n_tmo;
    send_byte(a); exp_a = a;
    if (bytes_in == 2) begin
      send_byte(b); exp_b = b;
    end
    idle(T - 1);
    chk("tmo_early", 32'(o_timeout), 0);
    @(negedge clk);
    chk("tmo_pulse", 32'(o_timeout), 1);
    chk("tmo_busy",  32'(o_busy),    0);
    @(negedge clk);
    chk("tmo_once",  32'(o_timeout), 0);
    chk("tmo_count", 32'(n_tmo - t0), 1);
    chk("tmo_a_kept", 32'(o_dato_a), 32'(exp_a));
    chk("tmo_b_kept", 32'(o_dato_b), 32'(exp_b));
    chk("tmo_op_kept", 32'(o_opcode), 32'(exp_op));
    $display("timeout after %0d byte(s) a=0x%02h, pulses=%0d", bytes_in, a, n_tmo - t0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [NB_OPCODE-1:0] op_list [8];

  initial begin
    int s0;
    op_list = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
    i_reset   = 1'b1;
    i_rx_data = '0;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    exp_a = '0; exp_b = '0; exp_op = '0;

    // 1. Reset
    idle(3);
    i_reset = 1'b0;
    check_zero("rst");
    $display("reset: outputs cleared");
    // stray tx_done outside WAIT_TX must be ignored
    i_tx_done = 1'b1; @(negedge clk); i_tx_done = 1'b0;
    chk("stray_txdone_busy", 32'(o_busy), 0);

    // 2. ADD frame
    do_frame(8'h05, 8'h03, 8'h20, 0, 0, 1'b0, -1, 3);
    chk("add_txd", 32'(o_tx_data), 32'h08);

    // 3. Opcode masking: 0xE6 -> XOR
    do_frame(8'hF0, 8'h0F, 8'hE6, 1, 2, 1'b0, -1, 2);
    chk("mask_op",  32'(o_opcode),  32'h26);
    chk("mask_txd", 32'(o_tx_data), 32'hFF);

    // 4. Timeout then a fresh frame; byte on the terminal-count cycle wins
    do_timeout(1, 8'h11, 8'h00);
    do_frame(8'h02, 8'h01, 8'h22, 0, 0, 1'b0, -1, 1);
    chk("post_tmo_txd", 32'(o_tx_data), 32'h01);
    do_frame(8'h09, 8'h04, 8'h24, T - 1, T - 1, 1'b0, -1, 1);
    do_timeout(2, 8'h33, 8'h44);

    // 5. Bytes during LATCH and WAIT_TX are dropped
    do_frame(8'h21, 8'h12, 8'h25, 0, 0, 1'b1, 1, 4);
    send_byte(8'h3C); exp_a = 8'h3C;
    chk("after_drop_a", 32'(o_dato_a), 32'h3C);
    send_byte(8'h01); exp_b = 8'h01;
    send_byte(8'h20); exp_op = 6'h20;
    idle(2);
    chk("after_drop_txd", 32'(o_tx_data), 32'h3D);
    i_tx_done = 1'b1; @(negedge clk); i_tx_done = 1'b0;
    chk("after_drop_busy", 32'(o_busy), 0);
    $display("drop test: a=0x3C b=0x01 op=ADD tx_data=0x%02h", o_tx_data);

    // 6. Reset in WAIT_OP, then in WAIT_TX
    send_byte(8'hAA); send_byte(8'hBB);
    pulse_reset(1);
    check_zero("rst_wop");
    send_byte(8'h5E); exp_a = 8'h5E;
    chk("rst_wop_a", 32'(o_dato_a), 32'h5E);
    chk("rst_wop_b", 32'(o_dato_b), 0);
    $display("reset in WAIT_OP: next byte loaded A=0x%02h", o_dato_a);
    pulse_reset(1);
    check_zero("rst_clr");
    send_byte(8'h07); send_byte(8'h08); send_byte(8'h26);
    idle(3);
    chk("rst_wtx_busy_pre", 32'(o_busy), 1);
    s0 = n_start;
    pulse_reset(1);
    check_zero("rst_wtx");
    idle(5);
    chk("rst_wtx_nostart", 32'(n_start - s0), 0);
    chk("rst_wtx_busy",    32'(o_busy), 0);
    $display("reset in WAIT_TX: start pulses afterwards=%0d", n_start - s0);

    // Randomized frames, occasional timeouts
    for (int k = 0; k < 24; k++) begin
      logic [7:0] ra, rb, rop;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = {2'($urandom), op_list[$urandom_range(0, 7)]};
      if ($urandom_range(0, 5) == 0) begin
        do_timeout($urandom_range(1, 2), ra, rb);
      end else begin
        do_frame(ra, rb, rop, $urandom_range(0, T - 1), $urandom_range(0, T - 1),
                 1'($urandom), $urandom_range(0, 5) - 1, $urandom_range(1, 6));
      end
      idle($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
